instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
- Fetch stage of the 5-stage pipelined processor.
- Holds the PC and drives the byte-addressed instruction memory's address port, which has a combinational read returning a big-endian 32-bit word.
- Registers the returned word into the IF/ID pipeline register.
- Honours load-use stalls, flushes and branch/jump redirects from downstream stages, and detects the halt word.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- MEM_BYTES, `INS_SIZE*`FACTOR, instruction memory size in bytes; fetch at or beyond it is out of range.
- HALT_WORD, 32'hFFFF_FFFF, instruction encoding that stops fetch.
- NOP_WORD, 32'h0000_0000, bubble encoding inserted into IF/ID.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hazard unit hold: PC and IF/ID keep their values.
- flush  in  1  bubble IF/ID without changing PC.
- redirect_en  in  1  taken branch/jump from a later stage.
- redirect_pc  in  32  redirect target.
- imem_addr  out  32  byte address to instruction memory.
- imem_data  in  32  instruction word from memory, same cycle.
- ifid_instr  out  32  registered instruction.
- ifid_pc  out  32  registered PC of that instruction.
- ifid_pc4  out  32  registered PC+4.
- ifid_valid  out  1  1 = real instruction, 0 = bubble.
- halted  out  1  fetch stopped: halt word fetched, or PC out of range.

Behaviour:
- Reset (asynchronous, immediate):
  - pc = RESET_PC.
  - ifid_instr = NOP_WORD, ifid_pc = 0, ifid_pc4 = 0, ifid_valid = 0, halted = 0.
  - Reset mid-operation discards all in-flight state.
- imem_addr = pc, combinational. It is valid in the same cycle, and IF/ID captures imem_data at the next rising edge, so memory-to-decode latency is 1 cycle.
- Per rising edge, first matching rule wins:
  1. redirect_en:
     - pc <= {redirect_pc[31:2], 2'b00}; low bits are forced to zero.
     - IF/ID <= bubble.
     - halted <= 0, since a halt fetched on the wrong path is cancelled.
     - Overrides stall and flush.
  2. flush:
     - IF/ID <= bubble; pc holds.
     - halted unchanged. Overrides stall.
  3. stall: pc, IF/ID and halted all hold.
  4. halted = 1: pc holds; IF/ID <= bubble.
  5. pc >= MEM_BYTES:
     - halted <= 1; IF/ID <= bubble; pc holds.
     - The memory must not be read out of range, so no word from that address is captured.
  6. imem_data == HALT_WORD:
     - IF/ID <= {HALT_WORD, pc, pc+4, valid=1}, so the halt propagates downstream.
     - halted <= 1; pc holds.
  7. Normal:
     - IF/ID <= {imem_data, pc, pc+4, valid=1}.
     - pc <= pc+4.
- Bubble = {NOP_WORD, pc field 0, pc4 field 0, valid 0}.
- Arithmetic: pc+4 is 32-bit modulo 2^32 (0xFFFF_FFFC + 4 = 0). Out-of-range detection normally halts before any wrap.
- Memory is word-aligned big-endian: byte at pc is bits [31:24]. This stage does no byte reassembly.
- State machine: two states, internal to halted.
  - FETCH -> HALT on rules 5/6.
  - HALT -> FETCH only on redirect_en or rst.
- Simultaneous events:
  - stall with redirect: redirect wins.
  - flush with stall: flush wins, producing a bubble while pc holds.

Decomposition:
- constants.v, shared package:
  - Existing: `WORD (32), `BYTE (8), `INS_SIZE, `FACTOR.
  - Added: `HALT_WORD, `NOP_WORD, `RESET_PC.
- One natural sub-module, if_id_reg: the IF/ID register with async reset, hold (stall), bubble-load (flush) and normal load.
- instruction_fetch keeps the PC register, next-PC priority mux and halt/range logic.

Test Plan:
- Reset released, memory holds 0x20010005 at 0, 0x20020003 at 4:
  - Cycle 1: ifid_instr = 0x20010005, ifid_pc = 0, ifid_pc4 = 4, ifid_valid = 1.
  - Cycle 2: ifid_instr = 0x20020003, ifid_pc = 4. imem_addr steps 0, 4, 8.
- stall held for 2 cycles at pc = 8: imem_addr stays 8 and IF/ID is unchanged for both edges; after release, the instruction at 8 is captured with ifid_pc = 8.
- redirect_en with redirect_pc = 0x23 and stall = 1 asserted together: next cycle imem_addr = 0x20 and ifid_valid = 0; the following cycle ifid_pc = 0x20.
- HALT_WORD at address 0xC:
  - ifid_instr = 0xFFFFFFFF with ifid_valid = 1, and halted = 1.
  - imem_addr frozen at 0xC; subsequent IF/ID are bubbles.
  - A later redirect to 0 clears halted and resumes fetch.
- MEM_BYTES = 16, straight-line code: after fetching pc = 0xC, pc = 0x10 sets halted = 1 with no valid capture.
- rst pulsed asynchronously mid-cycle while pc = 0x8: outputs go to reset values immediately, not at the clock edge; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// Shared constants and types for the fetch stage: word geometry, memory sizing,
// special instruction encodings and the small enums used by fetch control.
package instruction_fetch_pkg;

  localparam int WORD     = 32;
  localparam int BYTE     = 8;
  localparam int INS_SIZE = 64;
  localparam int FACTOR   = 4;

  localparam logic [WORD-1:0] HALT_WORD_C = 32'hFFFF_FFFF;
  localparam logic [WORD-1:0] NOP_WORD_C  = 32'h0000_0000;
  localparam logic [WORD-1:0] RESET_PC_C  = 32'h0000_0000;

  // One extra bit so a memory spanning the full 4 GiB space is still expressible.
  localparam logic [WORD:0]   MEM_BYTES_C = (WORD+1)'(INS_SIZE * FACTOR);
  localparam logic [WORD-1:0] PC_STEP     = 32'(WORD / BYTE);

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_HALT  = 1'b1
  } fetch_state_t;

  typedef enum logic [1:0] {
    IFID_HOLD   = 2'd0,
    IFID_BUBBLE = 2'd1,
    IFID_LOAD   = 2'd2
  } ifid_op_t;

endpackage

// File: rtl/instruction_fetch_if_id_reg.sv
// IF/ID pipeline register: holds, loads a bubble, or captures the fetched
// instruction with its PC and PC+4.
module instruction_fetch_if_id_reg
  import instruction_fetch_pkg::*;
#(
  parameter logic [WORD-1:0] NOP_WORD = NOP_WORD_C
) (
  input  logic            clk,
  input  logic            rst,
  input  ifid_op_t        op,
  input  logic [WORD-1:0] instr,
  input  logic [WORD-1:0] pc,
  input  logic [WORD-1:0] pc4,
  output logic [WORD-1:0] ifid_instr,
  output logic [WORD-1:0] ifid_pc,
  output logic [WORD-1:0] ifid_pc4,
  output logic            ifid_valid
);

  logic [WORD-1:0] instr_p1;
  logic [WORD-1:0] pc_p1;
  logic [WORD-1:0] pc4_p1;
  logic            vld_p1;

  // IF -> ID boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_p1 <= NOP_WORD;
      pc_p1    <= '0;
      pc4_p1   <= '0;
      vld_p1   <= 1'b0;
    end else begin
      case (op)
        IFID_BUBBLE: begin
          instr_p1 <= NOP_WORD;
          pc_p1    <= '0;
          pc4_p1   <= '0;
          vld_p1   <= 1'b0;
        end
        IFID_LOAD: begin
          instr_p1 <= instr;
          pc_p1    <= pc;
          pc4_p1   <= pc4;
          vld_p1   <= 1'b1;
        end
        default: begin
          instr_p1 <= instr_p1;
          pc_p1    <= pc_p1;
          pc4_p1   <= pc4_p1;
          vld_p1   <= vld_p1;
        end
      endcase
    end
  end

  assign ifid_instr = instr_p1;
  assign ifid_pc    = pc_p1;
  assign ifid_pc4   = pc4_p1;
  assign ifid_valid = vld_p1;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, drives the instruction memory address, and decides
// each cycle between redirect, flush, stall, halt and normal sequential fetch.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [WORD-1:0] RESET_PC  = RESET_PC_C,
  parameter logic [WORD:0]   MEM_BYTES = MEM_BYTES_C,
  parameter logic [WORD-1:0] HALT_WORD = HALT_WORD_C,
  parameter logic [WORD-1:0] NOP_WORD  = NOP_WORD_C
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            redirect_en,
  input  logic [WORD-1:0] redirect_pc,
  output logic [WORD-1:0] imem_addr,
  input  logic [WORD-1:0] imem_data,
  output logic [WORD-1:0] ifid_instr,
  output logic [WORD-1:0] ifid_pc,
  output logic [WORD-1:0] ifid_pc4,
  output logic            ifid_valid,
  output logic            halted
);

  fetch_state_t    state, state_nxt;
  logic [WORD-1:0] pc_p0, pc_nxt;
  logic [WORD-1:0] pc4_p0;
  logic            out_of_range;
  ifid_op_t        ifid_op;

  assign pc4_p0       = pc_p0 + PC_STEP;
  assign out_of_range = ({1'b0, pc_p0} >= MEM_BYTES);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_FETCH;
      pc_p0 <= RESET_PC;
    end else begin
      state <= state_nxt;
      pc_p0 <= pc_nxt;
    end
  end

  // Priority order matters: a redirect cancels any wrong-path halt, and an
  // out-of-range PC is caught before its (meaningless) memory word is looked at.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_p0;
    ifid_op   = IFID_HOLD;
    if (redirect_en) begin
      pc_nxt    = redirect_pc & ~32'h3;
      ifid_op   = IFID_BUBBLE;
      state_nxt = ST_FETCH;
    end else if (flush) begin
      ifid_op = IFID_BUBBLE;
    end else if (stall) begin
      ifid_op = IFID_HOLD;
    end else if (state == ST_HALT) begin
      ifid_op = IFID_BUBBLE;
    end else if (out_of_range) begin
      ifid_op   = IFID_BUBBLE;
      state_nxt = ST_HALT;
    end else if (imem_data == HALT_WORD) begin
      ifid_op   = IFID_LOAD;
      state_nxt = ST_HALT;
    end else begin
      ifid_op = IFID_LOAD;
      pc_nxt  = pc4_p0;
    end
  end

  instruction_fetch_if_id_reg #(
    .NOP_WORD (NOP_WORD)
  ) u_if_id_reg (
    .clk        (clk),
    .rst        (rst),
    .op         (ifid_op),
    .instr      (imem_data),
    .pc         (pc_p0),
    .pc4        (pc4_p0),
    .ifid_instr (ifid_instr),
    .ifid_pc    (ifid_pc),
    .ifid_pc4   (ifid_pc4),
    .ifid_valid (ifid_valid)
  );

  assign imem_addr = pc_p0;
  assign halted    = (state == ST_HALT);

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed vector table, async reset and range
// corner sequences, then randomized traffic against a behavioural model.
module tb_instruction_fetch;
  import instruction_fetch_pkg::*;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;
  localparam logic [31:0] OOR  = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0, flush = 1'b0, redirect_en = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] imem_addr, imem_data, ifid_instr, ifid_pc, ifid_pc4;
  logic        ifid_valid, halted;

  logic [31:0] imem_addr_s, imem_data_s, ifid_instr_s, ifid_pc_s, ifid_pc4_s;
  logic        ifid_valid_s, halted_s;

  logic [31:0] mem [64];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign imem_data   = (imem_addr < 32'd256) ? mem[imem_addr[7:2]] : OOR;
  assign imem_data_s = (imem_addr_s < 32'd16) ? (32'h1000_0000 | imem_addr_s) : OOR;

  instruction_fetch #(.MEM_BYTES(33'd256)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .ifid_instr(ifid_instr), .ifid_pc(ifid_pc), .ifid_pc4(ifid_pc4),
    .ifid_valid(ifid_valid), .halted(halted)
  );

  instruction_fetch #(.MEM_BYTES(33'd16)) dut_s (
    .clk(clk), .rst(rst), .stall(1'b0), .flush(1'b0),
    .redirect_en(1'b0), .redirect_pc(32'h0),
    .imem_addr(imem_addr_s), .imem_data(imem_data_s),
    .ifid_instr(ifid_instr_s), .ifid_pc(ifid_pc_s), .ifid_pc4(ifid_pc4_s),
    .ifid_valid(ifid_valid_s), .halted(halted_s)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] addr, input logic [31:0] instr,
                           input logic [31:0] pc, input logic [31:0] pc4,
                           input logic v, input logic h);
    check({tag, " addr"},   imem_addr,          addr);
    check({tag, " instr"},  ifid_instr,         instr);
    check({tag, " pc"},     ifid_pc,            pc);
    check({tag, " pc4"},    ifid_pc4,           pc4);
    check({tag, " valid"},  {31'b0, ifid_valid}, {31'b0, v});
    check({tag, " halted"}, {31'b0, halted},     {31'b0, h});
  endtask

  typedef struct {
    logic        st, fl, re;
    logic [31:0] rpc;
    logic [31:0] addr, instr, pc, pc4;
    logic        v, h;
  } vec_t;

  vec_t tbl [17];

  // Behavioural model: architectural PC, halt flag and IF/ID contents.
  logic [31:0] m_pc, m_instr, m_ipc, m_ipc4;
  logic        m_v, m_halted;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a < 32'd256) ? mem[a[7:2]] : OOR;
  endfunction

  task automatic model_bubble();
    m_instr = 32'h0; m_ipc = 32'h0; m_ipc4 = 32'h0; m_v = 1'b0;
  endtask

  task automatic model_step(input logic st, input logic fl, input logic re, input logic [31:0] rpc);
    logic [31:0] w;
    if (re) begin
      m_pc = {rpc[31:2], 2'b00};
      m_halted = 1'b0;
      model_bubble();
    end else if (fl) begin
      model_bubble();
    end else if (st) begin
      m_pc = m_pc;
    end else if (m_halted) begin
      model_bubble();
    end else if (m_pc >= 32'd256) begin
      m_halted = 1'b1;
      model_bubble();
    end else begin
      w = mem_word(m_pc);
      m_instr = w; m_ipc = m_pc; m_ipc4 = m_pc + 32'd4; m_v = 1'b1;
      if (w == HALT) m_halted = 1'b1;
      else m_pc = m_pc + 32'd4;
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h1100_0000 + i;
    mem[0] = 32'h2001_0005;
    mem[1] = 32'h2002_0003;
    mem[2] = 32'h2003_0001;
    mem[3] = HALT;
    mem[8] = 32'h2004_0002;
    mem[9] = 32'h2005_0007;

    //          st    fl    re    rpc     addr    instr          pc      pc4     v     h
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 32'h0,  32'h4,  32'h2001_0005, 32'h0,  32'h4,  1'b1, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,  32'h8,  32'h2002_0003, 32'h4,  32'h8,  1'b1, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 32'h0,  32'h8,  32'h2002_0003, 32'h4,  32'h8,  1'b1, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 32'h0,  32'h8,  32'h2002_0003, 32'h4,  32'h8,  1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 32'h0,  32'hC,  32'h2003_0001, 32'h8,  32'hC,  1'b1, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 32'h23, 32'h20, 32'h0,         32'h0,  32'h0,  1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 32'h0,  32'h24, 32'h2004_0002, 32'h20, 32'h24, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 32'h0,  32'h24, 32'h0,         32'h0,  32'h0,  1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,  32'h28, 32'h2005_0007, 32'h24, 32'h28, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 32'h0,  32'h28, 32'h0,         32'h0,  32'h0,  1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 32'hC,  32'hC,  32'h0,         32'h0,  32'h0,  1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 32'h0,  32'hC,  HALT,          32'hC,  32'h10, 1'b1, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 32'h0,  32'hC,  32'h0,         32'h0,  32'h0,  1'b0, 1'b1};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 32'h0,  32'hC,  32'h0,         32'h0,  32'h0,  1'b0, 1'b1};
    tbl[14] = '{1'b0, 1'b0, 1'b1, 32'h0,  32'h0,  32'h0,         32'h0,  32'h0,  1'b0, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 32'h0,  32'h4,  32'h2001_0005, 32'h0,  32'h4,  1'b1, 1'b0};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 32'h0,  32'h8,  32'h2002_0003, 32'h4,  32'h8,  1'b1, 1'b0};

    #2;
    check_all("reset", 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    #10 rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      stall = tbl[i].st; flush = tbl[i].fl;
      redirect_en = tbl[i].re; redirect_pc = tbl[i].rpc;
      @(posedge clk); #1;
      check_all($sformatf("row%0d", i), tbl[i].addr, tbl[i].instr, tbl[i].pc,
                tbl[i].pc4, tbl[i].v, tbl[i].h);
    end
    stall = 1'b0; flush = 1'b0; redirect_en = 1'b0; redirect_pc = '0;

    // Async reset in the middle of a cycle while pc = 8.
    #2 rst = 1'b1;
    #1;
    check_all("async_rst", 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("async_rst small halted", {31'b0, halted_s}, 32'h0);
    #2 rst = 1'b0;

    // Restart from RESET_PC; small-memory instance runs off its 16-byte end.
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        check("restart pc", ifid_pc, 32'h0);
        check("restart instr", ifid_instr, 32'h2001_0005);
        check("restart valid", {31'b0, ifid_valid}, 32'h1);
      end
      if (k < 4) begin
        check($sformatf("range%0d pc", k), ifid_pc_s, 32'(4 * k));
        check($sformatf("range%0d instr", k), ifid_instr_s, 32'h1000_0000 | 32'(4 * k));
        check($sformatf("range%0d pc4", k), ifid_pc4_s, 32'(4 * k + 4));
        check($sformatf("range%0d valid", k), {31'b0, ifid_valid_s}, 32'h1);
        check($sformatf("range%0d halted", k), {31'b0, halted_s}, 32'h0);
      end else begin
        check($sformatf("range%0d addr", k), imem_addr_s, 32'h10);
        check($sformatf("range%0d instr", k), ifid_instr_s, 32'h0);
        check($sformatf("range%0d valid", k), {31'b0, ifid_valid_s}, 32'h0);
        check($sformatf("range%0d halted", k), {31'b0, halted_s}, 32'h1);
      end
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 64; i++)
      mem[i] = ($urandom_range(15) == 0) ? HALT : $urandom;
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    m_pc = 32'h0; m_halted = 1'b0;
    model_bubble();
    for (int c = 0; c < 400; c++) begin
      stall       = ($urandom_range(3) == 0);
      flush       = ($urandom_range(7) == 0);
      redirect_en = ($urandom_range(9) == 0);
      redirect_pc = ($urandom_range(7) == 0) ? $urandom : 32'($urandom_range(300));
      model_step(stall, flush, redirect_en, redirect_pc);
      @(posedge clk); #1;
      check_all($sformatf("rand%0d", c), m_pc, m_instr, m_ipc, m_ipc4, m_v, m_halted);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
